// File: rtl/soin_bpredictor_update_ctrl.sv
// Write-port scheduler for the predictor table RAM: post-reset/flush sweep,
// a small update FIFO, and deferral of writes that collide with the fetch lookup.
module soin_bpredictor_update_ctrl #(
    parameter int                INDEX_W      = 8,
    parameter int                DATA_W       = 32,
    parameter int                BE_W         = 4,
    parameter int                FIFO_DEPTH_L = 2,
    parameter logic [DATA_W-1:0] INIT_DATA    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    execute_bpredictor_update,
    input  logic [INDEX_W-1:0]      execute_bpredictor_index,
    input  logic [DATA_W-1:0]       execute_bpredictor_data,
    input  logic [BE_W-1:0]         execute_bpredictor_be,
    input  logic                    soin_bpredictor_flush,
    input  logic                    fetch_lookup_valid,
    input  logic [INDEX_W-1:0]      fetch_lookup_index,
    output logic                    up_wen,
    output logic [INDEX_W-1:0]      up_index,
    output logic [DATA_W-1:0]       up_data,
    output logic [BE_W-1:0]         up_be,
    output logic                    ctrl_busy,
    output logic [FIFO_DEPTH_L:0]   fifo_count,
    output logic [7:0]              drop_count
);

    localparam int                  DEPTH     = 1 << FIFO_DEPTH_L;
    localparam logic [FIFO_DEPTH_L:0] FULL    = (FIFO_DEPTH_L+1)'(DEPTH);
    localparam logic [INDEX_W-1:0]  LAST_IDX  = {INDEX_W{1'b1}};

    typedef enum logic {SWEEP, RUN} state_t;

    state_t                     state, state_nxt;
    logic [INDEX_W-1:0]         sweep_ctr, sweep_ctr_nxt;

    logic [INDEX_W-1:0]         fifo_index [DEPTH];
    logic [DATA_W-1:0]          fifo_data  [DEPTH];
    logic [BE_W-1:0]            fifo_be    [DEPTH];
    logic [FIFO_DEPTH_L-1:0]    rd_ptr, wr_ptr;
    logic [FIFO_DEPTH_L:0]      count;

    logic                       head_ok;
    logic                       do_pop, do_push, do_drop, fifo_clr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A blocked head stalls the whole queue so update order is never reordered.
    assign head_ok = (count != '0) &&
                     !(fetch_lookup_valid && (fifo_index[rd_ptr] == fetch_lookup_index));

    always_comb begin
        state_nxt     = state;
        sweep_ctr_nxt = sweep_ctr;
        up_wen        = 1'b0;
        up_index      = '0;
        up_data       = '0;
        up_be         = '0;
        do_pop        = 1'b0;
        do_push       = 1'b0;
        do_drop       = 1'b0;
        fifo_clr      = 1'b0;
        ctrl_busy     = (state == SWEEP);

        case (state)
            SWEEP: begin
                up_wen   = 1'b1;
                up_index = sweep_ctr;
                up_data  = INIT_DATA;
                up_be    = '1;
                if (soin_bpredictor_flush) begin
                    sweep_ctr_nxt = '0;
                end else if (sweep_ctr == LAST_IDX) begin
                    state_nxt     = RUN;
                    sweep_ctr_nxt = '0;
                end else begin
                    sweep_ctr_nxt = sweep_ctr + INDEX_W'(1);
                end
            end
            RUN: begin
                if (head_ok) begin
                    up_wen   = 1'b1;
                    up_index = fifo_index[rd_ptr];
                    up_data  = fifo_data[rd_ptr];
                    up_be    = fifo_be[rd_ptr];
                end
                if (soin_bpredictor_flush) begin
                    state_nxt     = SWEEP;
                    sweep_ctr_nxt = '0;
                    fifo_clr      = 1'b1;
                end else begin
                    do_pop  = head_ok;
                    do_push = execute_bpredictor_update && ((count != FULL) || head_ok);
                    do_drop = execute_bpredictor_update && (count == FULL) && !head_ok;
                end
            end
            default: state_nxt = SWEEP;
        endcase

        if (reset) begin
            up_wen   = 1'b0;
            up_index = '0;
            up_data  = '0;
            up_be    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SWEEP;
            sweep_ctr  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ctr <= sweep_ctr_nxt;
            if (fifo_clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_pop)
                    rd_ptr <= rd_ptr + FIFO_DEPTH_L'(1);
                if (do_push)
                    wr_ptr <= wr_ptr + FIFO_DEPTH_L'(1);
                if (do_push && !do_pop)
                    count <= count + (FIFO_DEPTH_L+1)'(1);
                else if (do_pop && !do_push)
                    count <= count - (FIFO_DEPTH_L+1)'(1);
            end
            if (do_drop)
                drop_count <= sat_inc(drop_count);
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_index[wr_ptr] <= execute_bpredictor_index;
            fifo_data[wr_ptr]  <= execute_bpredictor_data;
            fifo_be[wr_ptr]    <= execute_bpredictor_be;
        end
    end

    assign fifo_count = count;

endmodule
